// File: rtl/adc_gate_window_if.sv
// Signal bundle between the ADC gate and its neighbours: ADC stream and
// configuration in, gated stream and averager command out.
interface adc_gate_window_if #(
    parameter int INT_IN_DATA_WIDTH  = 14,
    parameter int INT_MAX_AVERAGE_BY = 40,
    parameter int INT_DELAY_WIDTH    = 16
);
    localparam int IW = INT_IN_DATA_WIDTH;
    localparam int LW = $clog2(INT_MAX_AVERAGE_BY);
    localparam int DW = INT_DELAY_WIDTH;

    logic                 i_adc_valid;
    logic signed [IW-1:0] i_adc_data;
    logic                 i_trig;
    logic                 i_cfg_valid;
    logic [DW-1:0]        i_cfg_delay;
    logic [LW-1:0]        i_cfg_length;
    logic [DW-1:0]        i_cfg_holdoff;

    logic                 o_valid;
    logic signed [IW-1:0] o_data;
    logic                 o_avg_cmd_valid;
    logic [LW-1:0]        o_avg_cmd_data;
    logic                 o_busy;
    logic                 o_trig_missed;

    // Gate side
    modport slave (
        input  i_adc_valid, i_adc_data, i_trig,
        input  i_cfg_valid, i_cfg_delay, i_cfg_length, i_cfg_holdoff,
        output o_valid, o_data, o_avg_cmd_valid, o_avg_cmd_data,
        output o_busy, o_trig_missed
    );

    // Source / observer side
    modport master (
        output i_adc_valid, i_adc_data, i_trig,
        output i_cfg_valid, i_cfg_delay, i_cfg_length, i_cfg_holdoff,
        input  o_valid, o_data, o_avg_cmd_valid, o_avg_cmd_data,
        input  o_busy, o_trig_missed
    );
endinterface

// File: rtl/adc_gate_window.sv
// Trigger-aligned acquisition gate in front of the averager. After a trigger
// edge it waits a programmable delay, forwards exactly L+1 valid ADC samples,
// then enforces a holdoff. Config changes only take effect while idle so the
// averager length always matches the window that produced the samples.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  S_IDLE    | waiting for trigger edge; config applied here
//  S_DELAY   | counting trigger-to-gate delay (cnt_q)
//  S_GATE    | forwarding valid samples until L+1 accepted (scnt_q)
//  S_HOLDOFF | post-window dead time (cnt_q); triggers ignored
module adc_gate_window #(
    parameter int INT_IN_DATA_WIDTH  = 14,
    parameter int INT_MAX_AVERAGE_BY = 40,
    parameter int INT_DELAY_WIDTH    = 16
) (
    input logic              clk,
    input logic              rst,
    adc_gate_window_if.slave bus
);
    localparam int IW = INT_IN_DATA_WIDTH;
    localparam int LW = $clog2(INT_MAX_AVERAGE_BY);
    localparam int DW = INT_DELAY_WIDTH;
    localparam logic [LW-1:0] L_MAX = LW'(INT_MAX_AVERAGE_BY - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_GATE, S_HOLDOFF} state_t;

    state_t               state_q;
    logic                 trig_q;
    logic [DW-1:0]        cnt_q;
    logic [LW-1:0]        scnt_q;

    logic [DW-1:0]        delay_q;
    logic [LW-1:0]        len_q;
    logic [DW-1:0]        hold_q;
    logic                 pend_q;
    logic [DW-1:0]        pend_delay_q;
    logic [LW-1:0]        pend_len_q;
    logic [DW-1:0]        pend_hold_q;

    logic                 valid_q;
    logic signed [IW-1:0] data_q;
    logic                 cmd_valid_q;
    logic [LW-1:0]        cmd_data_q;
    logic                 missed_q;

    logic                 trig_edge;
    logic                 accept;
    logic [LW-1:0]        cfg_len_sat;
    logic                 apply_d;
    logic [DW-1:0]        delay_d;
    logic [LW-1:0]        len_d;
    logic [DW-1:0]        hold_d;

    assign trig_edge   = bus.i_trig & ~trig_q;
    assign accept      = (state_q == S_GATE) & bus.i_adc_valid;
    assign cfg_len_sat = (bus.i_cfg_length > L_MAX) ? L_MAX : bus.i_cfg_length;

    // Effective config for this cycle: a fresh write beats a pending one, and a
    // trigger in the same idle cycle already sees the new values.
    always_comb begin
        apply_d = 1'b0;
        delay_d = delay_q;
        len_d   = len_q;
        hold_d  = hold_q;
        if (state_q == S_IDLE) begin
            if (bus.i_cfg_valid) begin
                apply_d = 1'b1;
                delay_d = bus.i_cfg_delay;
                len_d   = cfg_len_sat;
                hold_d  = bus.i_cfg_holdoff;
            end else if (pend_q) begin
                apply_d = 1'b1;
                delay_d = pend_delay_q;
                len_d   = pend_len_q;
                hold_d  = pend_hold_q;
            end
        end
    end

    // Active/pending config registers and the averager length command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay_q      <= '0;
            len_q        <= L_MAX;
            hold_q       <= '0;
            pend_q       <= 1'b0;
            pend_delay_q <= '0;
            pend_len_q   <= '0;
            pend_hold_q  <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= '0;
        end else begin
            cmd_valid_q <= apply_d;
            cmd_data_q  <= apply_d ? len_d : '0;
            if (apply_d) begin
                delay_q <= delay_d;
                len_q   <= len_d;
                hold_q  <= hold_d;
                pend_q  <= 1'b0;
            end else if (bus.i_cfg_valid) begin
                pend_q       <= 1'b1;
                pend_delay_q <= bus.i_cfg_delay;
                pend_len_q   <= cfg_len_sat;
                pend_hold_q  <= bus.i_cfg_holdoff;
            end
        end
    end

    // Window FSM with registered sample and trigger-miss outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            trig_q   <= 1'b1;
            cnt_q    <= '0;
            scnt_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            missed_q <= 1'b0;
        end else begin
            trig_q   <= bus.i_trig;
            valid_q  <= accept;
            data_q   <= accept ? bus.i_adc_data : '0;
            missed_q <= trig_edge & (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (trig_edge) begin
                        scnt_q <= '0;
                        if (delay_d == '0) begin
                            state_q <= S_GATE;
                        end else begin
                            cnt_q   <= delay_d;
                            state_q <= S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_q <= DW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= S_GATE;
                    end else begin
                        cnt_q <= cnt_q - DW'(1);
                    end
                end
                S_GATE: begin
                    if (bus.i_adc_valid) begin
                        if (scnt_q >= len_q) begin
                            if (hold_q == '0) begin
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q   <= hold_q;
                                state_q <= S_HOLDOFF;
                            end
                        end else begin
                            scnt_q <= scnt_q + LW'(1);
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q <= DW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - DW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_valid         = valid_q;
    assign bus.o_data          = data_q;
    assign bus.o_avg_cmd_valid = cmd_valid_q;
    assign bus.o_avg_cmd_data  = cmd_data_q;
    assign bus.o_busy          = (state_q != S_IDLE);
    assign bus.o_trig_missed   = missed_q;
endmodule

// File: tb/tb_adc_gate_window.sv
// Bench for adc_gate_window: a cycle table for the basic delayed window,
// hand sequences for the multi-cycle corners, and a randomized run against a
// time-based reference model of the windowing rules.
`timescale 1ns/1ps
module tb_adc_gate_window;
    localparam int IW     = 14;
    localparam int MAXAVG = 40;
    localparam int DW     = 16;
    localparam int LW     = $clog2(MAXAVG);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adc_gate_window_if #(.INT_IN_DATA_WIDTH(IW), .INT_MAX_AVERAGE_BY(MAXAVG),
                         .INT_DELAY_WIDTH(DW)) bus ();

    adc_gate_window #(.INT_IN_DATA_WIDTH(IW), .INT_MAX_AVERAGE_BY(MAXAVG),
                      .INT_DELAY_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic trig, input logic av, input int ad,
                       input logic cv, input int cd, input int cl, input int ch);
        bus.i_trig        = trig;
        bus.i_adc_valid   = av;
        bus.i_adc_data    = IW'(ad);
        bus.i_cfg_valid   = cv;
        bus.i_cfg_delay   = DW'(cd);
        bus.i_cfg_length  = LW'(cl);
        bus.i_cfg_holdoff = DW'(ch);
    endtask

    task automatic chk_all(input string tag, input logic ev, input int ed, input logic eb,
                           input logic ec, input int ecd, input logic em);
        check({tag, ".valid"},  longint'(bus.o_valid), longint'(ev));
        check({tag, ".data"},   longint'($signed(bus.o_data)), longint'(ed));
        check({tag, ".busy"},   longint'(bus.o_busy), longint'(eb));
        check({tag, ".cmd"},    longint'(bus.o_avg_cmd_valid), longint'(ec));
        check({tag, ".cmdd"},   longint'(bus.o_avg_cmd_data), longint'(ecd));
        check({tag, ".missed"}, longint'(bus.o_trig_missed), longint'(em));
    endtask

    typedef struct {
        logic trig; logic av; int ad; logic cv; int cd; int cl; int ch;
        logic ev; int ed; logic eb; logic ec; int ecd; logic em;
    } vec_t;
    vec_t tbl[13];

    function automatic vec_t mk(input logic trig, input int ad, input logic cv,
                                input logic ev, input int ed, input logic eb,
                                input logic ec, input int ecd);
        vec_t v;
        v.trig = trig; v.av = 1'b1; v.ad = ad; v.cv = cv; v.cd = 5; v.cl = 3; v.ch = 0;
        v.ev = ev; v.ed = ed; v.eb = eb; v.ec = ec; v.ecd = ecd; v.em = 1'b0;
        return v;
    endfunction

    // Reference model state (random phase)
    int   m_cyc, m_gate_from, m_rem, m_last, m_hold;
    bit   m_active, m_done, m_prev_trig;
    int   a_delay, a_len, a_hold;
    bit   p_valid;
    int   p_delay, p_len, p_hold;
    bit   e_valid, e_cmd, e_missed;
    int   e_data, e_cmdd;

    function automatic int sat_len(input int l);
        return (l > MAXAVG - 1) ? MAXAVG - 1 : l;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, errs, miss, nv, ncmd;
        logic r_trig, r_av, r_cv;
        int r_ad, r_cd, r_cl, r_ch;
        bit edge_m;

        // T1: reset state, then release with trigger held high
        drv(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_all("t1_in_reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk_all($sformatf("t1_held[%0d]", j), 0, 0, 0, 0, 0, 0);
        end

        // T2: table-driven delayed window, delay=5 L=3 holdoff=0
        tbl[0]  = mk(0,  11, 1, 0,   0, 0, 1, 3);
        tbl[1]  = mk(1,  12, 0, 0,   0, 1, 0, 0);
        tbl[2]  = mk(1,  13, 0, 0,   0, 1, 0, 0);
        tbl[3]  = mk(1,  14, 0, 0,   0, 1, 0, 0);
        tbl[4]  = mk(1,  15, 0, 0,   0, 1, 0, 0);
        tbl[5]  = mk(1,  16, 0, 0,   0, 1, 0, 0);
        tbl[6]  = mk(1,  17, 0, 0,   0, 1, 0, 0);
        tbl[7]  = mk(1, -41, 0, 1, -41, 1, 0, 0);
        tbl[8]  = mk(1,  -4, 0, 1,  -4, 1, 0, 0);
        tbl[9]  = mk(1,  33, 0, 1,  33, 1, 0, 0);
        tbl[10] = mk(1,  70, 0, 1,  70, 0, 0, 0);
        tbl[11] = mk(1,  99, 0, 0,   0, 0, 0, 0);
        tbl[12] = mk(0, 100, 0, 0,   0, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            drv(tbl[k].trig, tbl[k].av, tbl[k].ad, tbl[k].cv, tbl[k].cd, tbl[k].cl, tbl[k].ch);
            @(negedge clk);
            chk_all($sformatf("t2_tbl[%0d]", k), tbl[k].ev, tbl[k].ed, tbl[k].eb,
                    tbl[k].ec, tbl[k].ecd, tbl[k].em);
        end

        // T3: L=39, valid 1-in-3
        drv(0, 0, 0, 1, 2, 39, 0);
        @(negedge clk);
        check("t3_cmd_data", longint'(bus.o_avg_cmd_data), 39);
        cnt = 0; errs = 0;
        for (int j = 0; j < 160; j++) begin
            r_av = (j % 3 == 0);
            r_ad = int'($urandom_range(0, 16383)) - 8192;
            drv(1, r_av, r_ad, 0, 0, 0, 0);
            @(negedge clk);
            if (bus.o_valid) begin
                cnt++;
                if (!r_av || $signed(bus.o_data) != r_ad) errs++;
            end else if (bus.o_data != '0) begin
                errs++;
            end
        end
        check("t3_count", cnt, 40);
        check("t3_data_errs", errs, 0);
        check("t3_busy_end", longint'(bus.o_busy), 0);

        // T4: holdoff=10, ignored edge inside holdoff, accepted edge after it
        drv(0, 1, 0, 1, 0, 0, 10);
        @(negedge clk);
        miss = 0;
        for (int j = 0; j <= 14; j++) begin
            drv((j == 0 || j == 4 || j >= 13), 1, 200 + j, 0, 0, 0, 0);
            @(negedge clk);
            if (bus.o_trig_missed) begin
                miss++;
                check("t4_miss_at", j, 4);
            end
            if (j == 10) check("t4_busy_last_hold", longint'(bus.o_busy), 1);
            if (j == 11) check("t4_idle_after_hold", longint'(bus.o_busy), 0);
            if (j == 13) check("t4_second_start", longint'(bus.o_busy), 1);
            if (j == 14) check("t4_second_sample", longint'($signed(bus.o_data)), 214);
        end
        check("t4_miss_count", miss, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        check("t4_drained", longint'(bus.o_busy), 0);

        // T5: config writes during GATE deferred, last one wins
        drv(0, 1, 0, 1, 0, 6, 0);
        @(negedge clk);
        check("t5_base_cmd", longint'(bus.o_avg_cmd_data), 6);
        nv = 0; ncmd = 0;
        for (int j = 0; j <= 12; j++) begin
            drv(1, 1, 1000 + j, (j == 2 || j == 4), 0, (j == 2) ? 7 : 5, 0);
            @(negedge clk);
            if (bus.o_valid) nv++;
            if (bus.o_avg_cmd_valid) begin
                ncmd++;
                check("t5_cmd_data", longint'(bus.o_avg_cmd_data), 5);
                check("t5_cmd_at", j, 8);
            end
        end
        check("t5_window_len", nv, 7);
        check("t5_cmd_count", ncmd, 1);
        drv(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        nv = 0;
        for (int j = 0; j < 12; j++) begin
            drv(1, 1, j, 0, 0, 0, 0);
            @(negedge clk);
            if (bus.o_valid) nv++;
        end
        check("t5_new_len", nv, 6);

        // T6: saturation, then reset mid-GATE
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        drv(0, 1, 0, 1, 0, 63, 0);
        @(negedge clk);
        check("t6_sat_cmd", longint'(bus.o_avg_cmd_valid), 1);
        check("t6_sat_data", longint'(bus.o_avg_cmd_data), 39);
        for (int j = 0; j <= 4; j++) begin
            drv(1, 1, 7 + j, (j == 2), 3, 3, 3);
            @(negedge clk);
        end
        check("t6_in_gate", longint'(bus.o_valid), 1);
        #2 rst = 1'b0;
        #1 chk_all("t6_async_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drv(0, 1, 5, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_no_pending_cmd", longint'(bus.o_avg_cmd_valid), 0);
        nv = 0; ncmd = 0;
        for (int j = 0; j < 50; j++) begin
            drv(1, 1, 300 + j, 0, 0, 0, 0);
            @(negedge clk);
            if (j == 0) check("t6_def_delay0_busy", longint'(bus.o_busy), 1);
            if (j == 1) check("t6_def_first_sample", longint'($signed(bus.o_data)), 301);
            if (bus.o_valid) nv++;
            if (bus.o_avg_cmd_valid) ncmd++;
        end
        check("t6_def_len", nv, 40);
        check("t6_def_cmds", ncmd, 0);
        check("t6_def_idle", longint'(bus.o_busy), 0);

        // Randomized run against the reference model
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_cyc = 0; m_active = 0; m_done = 0; m_prev_trig = 1;
        m_gate_from = 0; m_rem = 0; m_last = 0; m_hold = 0;
        a_delay = 0; a_len = MAXAVG - 1; a_hold = 0; p_valid = 0;
        p_delay = 0; p_len = 0; p_hold = 0;
        e_valid = 0; e_data = 0; e_cmd = 0; e_cmdd = 0; e_missed = 0;
        r_trig = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_active && m_done && m_cyc > m_last + m_hold) m_active = 0;
            chk_all($sformatf("rnd[%0d]", i), e_valid, e_data, m_active, e_cmd, e_cmdd, e_missed);

            if ($urandom_range(0, 5) == 0) r_trig = ~r_trig;
            r_av = ($urandom_range(0, 2) != 0);
            r_ad = int'($urandom_range(0, 16383)) - 8192;
            r_cv = ($urandom_range(0, 19) == 0);
            r_cd = int'($urandom_range(0, 6));
            r_cl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
            r_ch = int'($urandom_range(0, 5));
            drv(r_trig, r_av, r_ad, r_cv, r_cd, r_cl, r_ch);

            e_valid = 0; e_data = 0; e_cmd = 0; e_cmdd = 0; e_missed = 0;
            edge_m = r_trig && !m_prev_trig;
            m_prev_trig = r_trig;
            if (!m_active) begin
                if (r_cv) begin
                    a_delay = r_cd; a_len = sat_len(r_cl); a_hold = r_ch;
                    p_valid = 0; e_cmd = 1; e_cmdd = a_len;
                end else if (p_valid) begin
                    a_delay = p_delay; a_len = p_len; a_hold = p_hold;
                    p_valid = 0; e_cmd = 1; e_cmdd = a_len;
                end
                if (edge_m) begin
                    m_active = 1; m_done = 0;
                    m_gate_from = m_cyc + 1 + a_delay;
                    m_rem = a_len + 1; m_hold = a_hold;
                end
            end else begin
                if (r_cv) begin
                    p_valid = 1; p_delay = r_cd; p_len = sat_len(r_cl); p_hold = r_ch;
                end
                if (edge_m) e_missed = 1;
                if (!m_done && m_cyc >= m_gate_from && r_av) begin
                    e_valid = 1; e_data = r_ad;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1; m_last = m_cyc;
                    end
                end
            end
            m_cyc++;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
